circle_engine: RTL and testbench
================================

CIRCLE_ENGINE -- requirements
Module: circle_engine

Interface
Parameters (name, default, meaning):
REQ-001 XW, 8, pixel x coordinate width.
REQ-002 YW, 7, pixel y coordinate width.
REQ-003 RW, 6, radius width.
REQ-004 SCR_W, 160, screen width in pixels; legal x is 0..SCR_W-1.
REQ-005 SCR_H, 120, screen height in pixels; legal y is 0..SCR_H-1.
REQ-006 RMAX, 59, largest radius drawn; larger requests are clamped to RMAX.
Ports (name, direction, width, meaning):
REQ-007 CLK50, in, 1, sole clock; all state updates on the rising edge.
REQ-008 clearn, in, 1, asynchronous active-low reset.
REQ-009 start, in, 1, draw request; sampled only in IDLE.
REQ-010 clr, in, 1, screen-clear request; sampled only in IDLE.
REQ-011 fill, in, 1, filled-circle mode select; sampled with start.
REQ-012 xc, in, XW, centre x; sampled with start.
REQ-013 yc, in, YW, centre y; sampled with start.
REQ-014 rad, in, RW, radius; sampled with start.
REQ-015 color, in, 3, draw colour; sampled with start.
REQ-016 x, out, XW, registered pixel x.
REQ-017 y, out, YW, registered pixel y.
REQ-018 color_out, out, 3, registered pixel colour.
REQ-019 plot_en, out, 1, registered write strobe; x, y and color_out are valid only when plot_en=1.
REQ-020 busy, out, 1, high in every state except IDLE.
REQ-021 done, out, 1, one-cycle pulse on the final pixel of a draw or a clear.

Function
REQ-022 The FSM SHALL have four states: CLEAR, IDLE, OUTLINE, SPAN.
REQ-023 CLEAR: one pixel per cycle in row-major order from (0,0) to (SCR_W-1,SCR_H-1) with color_out=0 and plot_en=1; the FSM SHALL enter IDLE the cycle after the last pixel.
REQ-024 IDLE: plot_en=0. If clr=1, go to CLEAR. Otherwise, if start=1, latch the inputs and go to OUTLINE, or to SPAN when fill=1 and the fill feature is compiled in. clr SHALL take priority when clr and start are both high.
REQ-025 Effective radius r = RMAX if rad>RMAX, else rad.
REQ-026 r=0 SHALL plot only (xc,yc) in a single cycle, with done asserted on that cycle.
REQ-027 Midpoint state: offsets a=0, b=r; signed decision d=1-r, RW+3 bits wide. The first pixel SHALL appear one cycle after start is accepted.
REQ-028 OUTLINE: each iteration emits 8 pixels, one per cycle, in the fixed order (xc+a,yc+b), (xc-a,yc+b), (xc+a,yc-b), (xc-a,yc-b), (xc+b,yc+a), (xc-b,yc+a), (xc+b,yc-a), (xc-b,yc-a).
REQ-029 After each iteration: if d<0, then d+=2a+3; else d+=2(a-b)+5 and b-=1. Then a+=1. Iterate while a<=b. Duplicate pixels are permitted.
REQ-030 SPAN: each iteration emits four horizontal spans, one pixel per cycle, left to right: row yc+b over columns xc-a..xc+a; row yc-b over xc-a..xc+a; row yc+a over xc-b..xc+b; row yc-a over xc-b..xc+b.
REQ-031 Coordinate arithmetic SHALL use XW+1 / YW+1 signed width.
REQ-032 A pixel with x<0, x>=SCR_W, y<0 or y>=SCR_H SHALL be clipped: plot_en=0 on that cycle, while the step still consumes its cycle.
REQ-033 done SHALL assert on the cycle of the last emitted step, whether or not that step was clipped; the FSM SHALL be in IDLE on the next cycle.
REQ-034 start and clr asserted outside IDLE SHALL be ignored; no queueing.
REQ-035 Changes on xc, yc, rad, color or fill during a draw SHALL not affect it.

Reset
REQ-036 While clearn=0: state=CLEAR with counters at 0; x=0, y=0, color_out=0, plot_en=0, done=0, busy=1.
REQ-037 Reset asserted mid-draw SHALL abort the draw immediately; after release, a full CLEAR sweep SHALL run before IDLE.

Configuration
REQ-038 Macro CIRCLE_ENGINE_FILL_EN.
- Defined: the SPAN state and the fill input are functional.
- Undefined: SPAN logic is absent, fill is ignored, and every draw uses OUTLINE.

Verification
REQ-039 Release reset -> exactly 19200 plot_en cycles covering (0,0)..(159,119) with color 0, then one done pulse, then busy=0.
REQ-040 start with xc=80, yc=60, rad=3, color=5, fill=0 -> 3 iterations, 24 plot cycles; pixel set {(80,63),(83,60),(82,62),(78,58),...} matches a reference model; all pixels color 5.
REQ-041 rad=63 -> drawn as r=59; rad=0 -> single pixel (80,60) with done on that same cycle.
REQ-042 xc=2, yc=2, rad=5 -> every pixel with negative coordinates has plot_en=0; total cycle count equals the unclipped case.
REQ-043 With CIRCLE_ENGINE_FILL_EN defined, fill=1, rad=2 at (80,60) -> every pixel within the midpoint disk is plotted; clr and start asserted together in IDLE -> CLEAR runs.
REQ-044 Assert clearn=0 mid-OUTLINE -> plot_en falls to 0 at once; after release a 19200-pixel sweep runs before busy falls.

Source files
------------

// File: rtl/circle_engine.sv
// circle_engine: midpoint circle rasteriser with outline mode and full-screen clear sweep.
// Define CIRCLE_ENGINE_FILL_EN to build the filled-span (SPAN) mode driven by the fill input.
module circle_engine #(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int RW    = 6,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int RMAX  = 59
) (
    input  logic          CLK50,
    input  logic          clearn,
    input  logic          start,
    input  logic          clr,
    input  logic          fill,
    input  logic [XW-1:0] xc,
    input  logic [YW-1:0] yc,
    input  logic [RW-1:0] rad,
    input  logic [2:0]    color,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    color_out,
    output logic          plot_en,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {CLEAR, IDLE, OUTLINE, SPAN} state_t;

    localparam logic signed [RW+2:0] D1 = (RW+3)'(1);
    localparam logic signed [RW+2:0] D3 = (RW+3)'(3);
    localparam logic signed [RW+2:0] D5 = (RW+3)'(5);
    localparam logic [XW:0]   X_LIM = (XW+1)'(SCR_W);
    localparam logic [YW:0]   Y_LIM = (YW+1)'(SCR_H);
    localparam logic [XW-1:0] X_END = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_END = YW'(SCR_H - 1);
    localparam logic [RW-1:0] R_MAX = RW'(RMAX);

    state_t               r_state, w_state;
    logic [XW-1:0]        r_cx, w_cx_n, r_xc, w_xc, r_x, w_xo;
    logic [YW-1:0]        r_cy, w_cy_n, r_yc, w_yc, r_y, w_yo;
    logic [2:0]           r_col, w_col, r_co, w_co;
    logic [RW-1:0]        r_a, r_b, w_a, w_b, w_r, w_an, w_bn, w_a_n, w_b_n, w_mx, w_my;
    logic signed [RW+2:0] r_d, w_d, w_dn, w_d_n, w_ae, w_be;
    logic [2:0]           r_k, w_k, w_k_n;
    logic signed [RW:0]   w_s;
    logic [XW:0]          w_px;
    logic [YW:0]          w_py;
    logic                 r_plot, w_plot, r_done, w_done, w_idle, w_span, w_vis, w_last;

    // Step operands come straight from the inputs in IDLE so the first pixel leaves on the accept edge.
    assign w_idle = r_state == IDLE;
    assign w_r    = (rad > R_MAX) ? R_MAX : rad;
    assign w_xc   = w_idle ? xc : r_xc;
    assign w_yc   = w_idle ? yc : r_yc;
    assign w_col  = w_idle ? color : r_col;
    assign w_a    = w_idle ? '0 : r_a;
    assign w_b    = w_idle ? w_r : r_b;
    assign w_d    = w_idle ? D1 - $signed({3'b0, w_r}) : r_d;
    assign w_k    = w_idle ? '0 : r_k;

    assign w_ae   = $signed({3'b0, w_a});
    assign w_be   = $signed({3'b0, w_b});
    assign w_an   = w_a + 1'b1;
    assign w_bn   = w_d[RW+2] ? w_b : w_b - 1'b1;
    assign w_dn   = w_d[RW+2] ? w_d + (w_ae <<< 1) + D3 : w_d + ((w_ae - w_be) <<< 1) + D5;
    assign w_last = w_an > w_bn;

`ifdef CIRCLE_ENGINE_FILL_EN
    logic signed [RW:0] r_s, w_s_n;
    logic [RW-1:0]      w_sw;
    assign w_span = w_idle ? fill : r_state == SPAN;
    assign w_s    = w_idle ? '0 : r_s;
    assign w_sw   = w_k[1] ? w_b : w_a;
`else
    logic w_unused_fill;
    assign w_unused_fill = fill;
    assign w_span        = 1'b0;
    assign w_s           = '0;
`endif

    // Outline: r_k is the octant index; span: r_k[1:0] is the span index, w_s the column offset.
    assign w_mx  = w_k[2] ? w_b : w_a;
    assign w_my  = (w_span ? w_k[1] : w_k[2]) ? w_a : w_b;
    assign w_px  = w_span ? {1'b0, w_xc} + {{(XW-RW){w_s[RW]}}, w_s}
                 : w_k[0] ? {1'b0, w_xc} - {{(XW+1-RW){1'b0}}, w_mx}
                          : {1'b0, w_xc} + {{(XW+1-RW){1'b0}}, w_mx};
    assign w_py  = (w_span ? w_k[0] : w_k[1]) ? {1'b0, w_yc} - {{(YW+1-RW){1'b0}}, w_my}
                                              : {1'b0, w_yc} + {{(YW+1-RW){1'b0}}, w_my};
    assign w_vis = !w_px[XW] && w_px < X_LIM && !w_py[YW] && w_py < Y_LIM;

    always_comb begin
        w_state = r_state;
        w_cx_n  = r_cx;
        w_cy_n  = r_cy;
        w_a_n   = w_a;
        w_b_n   = w_b;
        w_d_n   = w_d;
        w_k_n   = w_k;
        w_xo    = w_px[XW-1:0];
        w_yo    = w_py[YW-1:0];
        w_co    = w_col;
        w_plot  = 1'b0;
        w_done  = 1'b0;
`ifdef CIRCLE_ENGINE_FILL_EN
        w_s_n   = w_s;
`endif
        if (r_done) begin
            w_state = IDLE;
        end else if (r_state == CLEAR || (w_idle && clr)) begin
            w_state = CLEAR;
            w_xo    = r_cx;
            w_yo    = r_cy;
            w_co    = '0;
            w_plot  = 1'b1;
            w_done  = r_cx == X_END && r_cy == Y_END;
            w_cx_n  = (r_cx == X_END) ? '0 : r_cx + 1'b1;
            w_cy_n  = (r_cx != X_END) ? r_cy : (r_cy == Y_END) ? '0 : r_cy + 1'b1;
        end else if (!w_idle || start) begin
            w_state = w_span ? SPAN : OUTLINE;
            w_plot  = w_vis;
            if (!w_span) begin
                w_done = w_b == '0 || (w_k == 3'd7 && w_last);
                w_k_n  = w_k + 1'b1;
                if (w_k == 3'd7) begin
                    w_a_n = w_an;
                    w_b_n = w_bn;
                    w_d_n = w_dn;
                end
            end
`ifdef CIRCLE_ENGINE_FILL_EN
            else begin
                w_done = w_b == '0 || (w_k[1:0] == 2'd3 && w_s == $signed({1'b0, w_sw}) && w_last);
                if (w_s != $signed({1'b0, w_sw})) begin
                    w_s_n = w_s + 1'b1;
                end else if (w_k[1:0] == 2'd3) begin
                    w_a_n = w_an;
                    w_b_n = w_bn;
                    w_d_n = w_dn;
                    w_k_n = '0;
                    w_s_n = -$signed({1'b0, w_an});
                end else begin
                    w_k_n = w_k + 1'b1;
                    w_s_n = -$signed({1'b0, (w_k[1:0] == 2'd0) ? w_a : w_b});
                end
            end
`endif
        end
    end

    always_ff @(posedge CLK50 or negedge clearn) begin
        if (!clearn) begin
            r_state <= CLEAR;
            r_cx    <= '0;
            r_cy    <= '0;
            r_xc    <= '0;
            r_yc    <= '0;
            r_col   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_co    <= '0;
            r_plot  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cx    <= w_cx_n;
            r_cy    <= w_cy_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_d     <= w_d_n;
            r_k     <= w_k_n;
            r_x     <= w_xo;
            r_y     <= w_yo;
            r_co    <= w_co;
            r_plot  <= w_plot;
            r_done  <= w_done;
            if (w_idle) begin
                r_xc  <= xc;
                r_yc  <= yc;
                r_col <= color;
            end
        end
    end

`ifdef CIRCLE_ENGINE_FILL_EN
    always_ff @(posedge CLK50 or negedge clearn) begin
        if (!clearn) r_s <= '0;
        else         r_s <= w_s_n;
    end
`endif

    assign x         = r_x;
    assign y         = r_y;
    assign color_out = r_co;
    assign plot_en   = r_plot;
    assign done      = r_done;
    assign busy      = !w_idle;
endmodule

// File: tb/tb_circle_engine.sv
// tb_circle_engine: directed scoreboard bench for circle_engine; expected pixel stream is
// generated from a behavioural midpoint model and compared cycle by cycle.
module tb_circle_engine;
    logic       CLK50 = 1'b0, clearn = 1'b0, start = 1'b0, clr = 1'b0, fill = 1'b0;
    logic [7:0] xc = '0;
    logic [6:0] yc = '0;
    logic [5:0] rad = '0;
    logic [2:0] color = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color_out;
    logic       plot_en, busy, done;

    typedef struct {int x; int y; int c; bit p; bit d;} step_t;
    step_t q[$];
    bit    seen [0:159][0:119];
    int    n_tests = 0, n_fail = 0, n, nc, nk;

    circle_engine dut (
        .CLK50(CLK50), .clearn(clearn), .start(start), .clr(clr), .fill(fill),
        .xc(xc), .yc(yc), .rad(rad), .color(color),
        .x(x), .y(y), .color_out(color_out), .plot_en(plot_en), .busy(busy), .done(done)
    );

    always #5 CLK50 = ~CLK50;

    function automatic void push(int px, int py, int c);
        step_t s;
        s.x = px; s.y = py; s.c = c; s.d = 1'b0;
        s.p = px >= 0 && px < 160 && py >= 0 && py < 120;
        q.push_back(s);
    endfunction

    function automatic void mark_last();
        step_t s = q.pop_back();
        s.d = 1'b1;
        q.push_back(s);
    endfunction

    function automatic void push_clear();
        for (int j = 0; j < 120; j++)
            for (int i = 0; i < 160; i++) push(i, j, 0);
        mark_last();
    endfunction

    function automatic void push_outline(int cx, int cy, int rq, int c);
        int r = rq > 59 ? 59 : rq;
        int a = 0, b = r, d = 1 - r;
        if (r == 0) push(cx, cy, c);
        while (r > 0 && a <= b) begin
            push(cx + a, cy + b, c); push(cx - a, cy + b, c);
            push(cx + a, cy - b, c); push(cx - a, cy - b, c);
            push(cx + b, cy + a, c); push(cx - b, cy + a, c);
            push(cx + b, cy - a, c); push(cx - b, cy - a, c);
            if (d < 0) d += 2 * a + 3;
            else begin d += 2 * (a - b) + 5; b--; end
            a++;
        end
        mark_last();
    endfunction

`ifdef CIRCLE_ENGINE_FILL_EN
    function automatic void push_span(int cx, int cy, int rq, int c);
        int r = rq > 59 ? 59 : rq;
        int a = 0, b = r, d = 1 - r;
        if (r == 0) push(cx, cy, c);
        while (r > 0 && a <= b) begin
            for (int s = -a; s <= a; s++) push(cx + s, cy + b, c);
            for (int s = -a; s <= a; s++) push(cx + s, cy - b, c);
            for (int s = -b; s <= b; s++) push(cx + s, cy + a, c);
            for (int s = -b; s <= b; s++) push(cx + s, cy - a, c);
            if (d < 0) d += 2 * a + 3;
            else begin d += 2 * (a - b) + 5; b--; end
            a++;
        end
        mark_last();
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumes the queue one step per cycle; poke re-asserts start/clr mid-draw with new inputs.
    task automatic run(input string tag, input bit poke, output int nb);
        int    i = 0;
        step_t e;
        nb = 0;
        for (int a = 0; a < 160; a++)
            for (int b = 0; b < 120; b++) seen[a][b] = 1'b0;
        while (q.size() > 0) begin
            @(posedge CLK50);
            @(negedge CLK50);
            i++;
            if (busy) nb++;
            if (plot_en) seen[x][y] = 1'b1;
            e = q.pop_front();
            check(tag, {12'd0, plot_en, done, plot_en ? {x, y, color_out} : 18'd0},
                  {12'd0, e.p, e.d, e.p ? {8'(e.x), 7'(e.y), 3'(e.c)} : 18'd0});
            start = poke && i >= 3 && i < 6;
            clr   = start;
            if (poke && i == 3) begin xc = 8'd0; rad = 6'd7; color = 3'd1; fill = !fill; end
        end
        @(posedge CLK50);
        @(negedge CLK50);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLK50);
        check("reset", {11'd0, x, y, color_out, plot_en, done, busy}, 32'd1);
        push_clear();
        clearn = 1'b1;
        run("clear_after_reset", 1'b0, n);
        check("clear_len", n, 19200);

        @(negedge CLK50);
        xc = 8'd80; yc = 7'd60; rad = 6'd3; color = 3'd5; fill = 1'b0; start = 1'b1;
        push_outline(80, 60, 3, 5);
        run("outline_r3", 1'b1, n);
        check("outline_r3_len", n, 24);
        check("px_80_63", {31'd0, seen[80][63]}, 32'd1);
        check("px_83_60", {31'd0, seen[83][60]}, 32'd1);
        check("px_82_62", {31'd0, seen[82][62]}, 32'd1);
        check("px_78_58", {31'd0, seen[78][58]}, 32'd1);

        @(negedge CLK50);
        xc = 8'd80; yc = 7'd60; rad = 6'd0; color = 3'd3; fill = 1'b0; start = 1'b1;
        push_outline(80, 60, 0, 3);
        run("outline_r0", 1'b0, n);
        check("outline_r0_len", n, 1);

        @(negedge CLK50);
        rad = 6'd63; color = 3'd2; start = 1'b1;
        push_outline(80, 60, 63, 2);
        run("outline_r63", 1'b0, n);

        @(negedge CLK50);
        rad = 6'd5; color = 3'd4; start = 1'b1;
        push_outline(80, 60, 5, 4);
        run("outline_r5", 1'b0, nc);
        @(negedge CLK50);
        xc = 8'd2; yc = 7'd2; start = 1'b1;
        push_outline(2, 2, 5, 4);
        run("clip_r5", 1'b0, nk);
        check("clip_len", nk, nc);

        @(negedge CLK50);
        xc = 8'd80; yc = 7'd60; rad = 6'd2; color = 3'd6; fill = 1'b1; start = 1'b1;
`ifdef CIRCLE_ENGINE_FILL_EN
        push_span(80, 60, 2, 6);
        run("fill_r2", 1'b0, n);
        for (int i = 78; i <= 82; i++)
            for (int j = 58; j <= 62; j++)
                check($sformatf("disk_%0d_%0d", i, j), {31'd0, seen[i][j]},
                      ((i - 80) * (i - 80) + (j - 60) * (j - 60) <= 5) ? 32'd1 : 32'd0);
`else
        push_outline(80, 60, 2, 6);
        run("fill_ignored_r2", 1'b0, n);
`endif
        fill = 1'b0;

        @(negedge CLK50);
        clr = 1'b1; start = 1'b1; rad = 6'd4;
        push_clear();
        run("clr_start", 1'b0, n);
        check("clr_start_len", n, 19200);

        @(negedge CLK50);
        xc = 8'd80; yc = 7'd60; rad = 6'd10; color = 3'd7; start = 1'b1;
        @(negedge CLK50);
        start = 1'b0;
        repeat (4) @(negedge CLK50);
        check("pre_abort_plot", {31'd0, plot_en}, 32'd1);
        #2 clearn = 1'b0;
        #1 check("abort", {29'd0, plot_en, done, busy}, 32'd1);
        q.delete();
        @(negedge CLK50);
        clearn = 1'b1;
        push_clear();
        run("clear_after_abort", 1'b0, n);
        check("clear_after_abort_len", n, 19200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
